// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues 1-cycle-latency imem reads and
// buffers returned words with their PCs in an in-order prefetch queue.
module ifetch_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic            imem_wr,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflightPc;
    logic            inflight;
    logic [XLEN-1:0] dataMem [DEPTH];
    logic [XLEN-1:0] pcMem   [DEPTH];
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;
    logic [CW-1:0]   count;
    logic            headValid;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     credit;

    always_comb begin
        headValid = (count != '0);
        // Redirect flushes the queue, so a same-cycle pop or landing response is dropped.
        pop    = headValid && inst_ready && !redirect_valid;
        push   = inflight && !redirect_valid;
        credit = {1'b0, count} + {{CW{1'b0}}, inflight}
               - {{CW{1'b0}}, (headValid && inst_ready)};
        issue  = fetch_en && !redirect_valid && !reset && (credit < (CW+1)'(DEPTH));
    end

    assign imem_req   = issue;
    assign imem_wr    = 1'b0;
    assign imem_addr  = {2'b00, pc[XLEN-1:2]};
    assign inst_valid = headValid;
    assign inst_data  = headValid ? dataMem[rdPtr] : '0;
    assign inst_pc    = headValid ? pcMem[rdPtr]   : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            inflightPc <= '0;
            inflight   <= 1'b0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & ~XLEN'(3);
            inflight <= 1'b0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                pc         <= pc + XLEN'(4);
                inflightPc <= pc;
            end
            inflight <= issue;
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            dataMem[wrPtr] <= imem_rdata;
            pcMem[wrPtr]   <= inflightPc;
        end
    end

    overflowCheck: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: behavioural imem (word i holds i) and a
// queue of expected {pc, data} pairs compared on every accepted instruction.
module tb_ifetch_ctrl;

    localparam int unsigned XLEN = 32;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            fetch_en = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            imem_req;
    logic            imem_wr;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata = '0;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    int   total = 0;
    int   bad = 0;
    exp_t expQ[$];

    ifetch_ctrl #(.XLEN(XLEN), .DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_wr(imem_wr), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    // Word-indexed memory with imem[i] = i; garbage when no request was made.
    always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 32'hDEAD_BEEF;

    function automatic void push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = {2'b00, pc[31:2]};
        expQ.push_back(e);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b, expected 0", imem_req); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, expected 0", inst_valid); end
        total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h, expected 0", inst_pc); end
        total++; if (inst_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h, expected 0", inst_data); end
        total++; if (imem_wr !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b, expected 0", imem_wr); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h, expected 0", imem_addr); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); fetch_en = 1'b1; inst_ready = 1'b1; #1;
            total++;
            if ({imem_req, imem_addr} !== {1'b1, 32'(k)}) begin
                bad++; $display("FAIL b2b_issue: got req/addr %b/%h, expected 1/%h", imem_req, imem_addr, 32'(k));
            end
            total++;
            if (inst_valid !== (k >= 2)) begin
                bad++; $display("FAIL b2b_valid: got %b at cycle %0d, expected %b", inst_valid, k, (k >= 2));
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("FAIL sb_extra: got pc %h, expected none", inst_pc); end
                else begin
                    e = expQ.pop_front();
                    if ({inst_pc, inst_data} !== {e.pc, e.data}) begin bad++; $display("FAIL sb_head: got %h/%h, expected %h/%h", inst_pc, inst_data, e.pc, e.data); end
                end
            end
        end
        total++; if (expQ.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d left, expected 0", expQ.size()); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   reqs = 0;
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); fetch_en = 1'b1; inst_ready = 1'b0; #1;
            if (imem_req) reqs++;
            if (inst_valid) begin
                total++;
                if ({inst_pc, inst_data} !== 64'h0) begin bad++; $display("FAIL bp_hold: got %h/%h, expected 0/0", inst_pc, inst_data); end
            end
        end
        total++; if (reqs != 2) begin bad++; $display("FAIL bp_reqs: got %0d, expected 2", reqs); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_off: got %b, expected 0", imem_req); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); inst_ready = 1'b1; #1;
            if (inst_valid && inst_ready && !redirect_valid) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("FAIL sb_extra: got pc %h, expected none", inst_pc); end
                else begin
                    e = expQ.pop_front();
                    if ({inst_pc, inst_data} !== {e.pc, e.data}) begin bad++; $display("FAIL sb_head: got %h/%h, expected %h/%h", inst_pc, inst_data, e.pc, e.data); end
                end
            end
        end
        total++; if (expQ.size() != 0) begin bad++; $display("FAIL bp_drain: got %0d left, expected 0", expQ.size()); end
    endtask

    // Redirect at cycle rdCycle of a stream; stale words must never reach the scoreboard.
    task automatic test_redirect(input logic [31:0] target, input int rdCycle,
                                 input logic readyBefore, input int cycles);
        exp_t        e;
        logic [31:0] base;
        do_reset();
        base = target & 32'hFFFF_FFFC;
        if (readyBefore) for (int i = 0; i < rdCycle - 2; i++) push_exp(32'(i * 4));
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            fetch_en = 1'b1;
            inst_ready = (c > rdCycle) ? 1'b1 : readyBefore;
            redirect_valid = (c == rdCycle);
            redirect_pc = target;
            if (c == rdCycle) for (int i = 0; i < cycles - rdCycle - 3; i++) push_exp(base + 32'(i * 4));
            #1;
            if (c == rdCycle) begin
                total++;
                if ({imem_req, inst_valid} !== 2'b01) begin bad++; $display("FAIL rd_cycle: got req/valid %b/%b, expected 0/1", imem_req, inst_valid); end
            end
            if (c == rdCycle + 1) begin
                total++;
                if ({imem_req, imem_addr, inst_valid} !== {1'b1, 2'b00, base[31:2], 1'b0}) begin
                    bad++; $display("FAIL rd_next: got req/addr/valid %b/%h/%b, expected 1/%h/0", imem_req, imem_addr, inst_valid, {2'b00, base[31:2]});
                end
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("FAIL sb_extra: got pc %h, expected none", inst_pc); end
                else begin
                    e = expQ.pop_front();
                    if ({inst_pc, inst_data} !== {e.pc, e.data}) begin bad++; $display("FAIL sb_head: got %h/%h, expected %h/%h", inst_pc, inst_data, e.pc, e.data); end
                end
            end
        end
        redirect_valid = 1'b0;
        total++; if (expQ.size() != 0) begin bad++; $display("FAIL rd_drain: got %0d left, expected 0", expQ.size()); end
    endtask

    task automatic test_wrap();
        exp_t e;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            fetch_en = 1'b1; inst_ready = 1'b1;
            redirect_valid = (c == 0); redirect_pc = 32'hFFFF_FFFC;
            if (c == 0) begin push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4); end
            #1;
            if (c == 1) begin
                total++;
                if ({imem_req, imem_addr} !== {1'b1, 32'h3FFF_FFFF}) begin bad++; $display("FAIL wrap_addr: got %b/%h, expected 1/3fffffff", imem_req, imem_addr); end
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("FAIL sb_extra: got pc %h, expected none", inst_pc); end
                else begin
                    e = expQ.pop_front();
                    if ({inst_pc, inst_data} !== {e.pc, e.data}) begin bad++; $display("FAIL sb_head: got %h/%h, expected %h/%h", inst_pc, inst_data, e.pc, e.data); end
                end
            end
        end
        redirect_valid = 1'b0;
        total++; if (expQ.size() != 0) begin bad++; $display("FAIL wrap_drain: got %0d left, expected 0", expQ.size()); end
    endtask

    task automatic test_reset_full();
        exp_t e;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); fetch_en = 1'b1; inst_ready = 1'b0; #1;
        end
        total++; if ({inst_valid, imem_req} !== 2'b10) begin bad++; $display("FAIL full_state: got valid/req %b/%b, expected 1/0", inst_valid, imem_req); end
        @(negedge clk); reset = 1'b1; #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL full_rst_req: got %b, expected 0", imem_req); end
        @(negedge clk); reset = 1'b0; expQ.delete();
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            inst_ready = 1'b1; #1;
            if (k == 0) begin
                total++;
                if ({inst_valid, imem_req, imem_addr} !== {2'b01, 32'h0}) begin
                    bad++; $display("FAIL full_post: got valid/req/addr %b/%b/%h, expected 0/1/0", inst_valid, imem_req, imem_addr);
                end
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                total++;
                if (expQ.size() == 0) begin bad++; $display("FAIL sb_extra: got pc %h, expected none", inst_pc); end
                else begin
                    e = expQ.pop_front();
                    if ({inst_pc, inst_data} !== {e.pc, e.data}) begin bad++; $display("FAIL sb_head: got %h/%h, expected %h/%h", inst_pc, inst_data, e.pc, e.data); end
                end
            end
        end
        total++; if (expQ.size() != 0) begin bad++; $display("FAIL full_drain: got %0d left, expected 0", expQ.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_redirect(32'h0000_0100, 2, 1'b0, 9);
        test_redirect(32'h0000_0103, 4, 1'b1, 9);
        test_wrap();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
